modular_inverter: RTL and testbench
===================================

# modular_inverter

Computes M = A⁻¹ mod p for an odd prime p using the binary extended Euclidean algorithm, one reduction step per clock. It is the counterpart of `modular_multiplier` in the ECDSA datapath. The multiplier produces products; this block produces the inverses consumed by the signing step (k⁻¹ mod n) and by affine point conversion (Z⁻¹ mod p). It uses the same operand/`flag` style as the multiplier, so control FSMs drive both identically.

## Interface
- `n`, 256, operand width in bits.
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset. Sampled on the `clk` edge; 0 resets the block.
- `start`  in  1  pulse; sampled only in IDLE; captures `A` and `p`.
- `A`  in  n  operand to invert.
- `p`  in  n  odd prime modulus; held stable for the whole operation.
- `M`  out  n  result A⁻¹ mod p; valid when `flag`=1 and held until the next accepted `start`.
- `flag`  out  1  done; high for exactly one cycle per operation.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `flag` is high.
- `err`  out  1  sampled with `flag`; 1 = no inverse (A≡0) or A out of range; M=0 in that case.

## Operation
- States:
  - IDLE: `start`=1 → LOAD.
  - LOAD: 1 cycle; range check, with optional reduction (see Configuration).
    - u←A, v←p, x1←1, x2←0.
    - A==0 or out of range → DONE with err=1.
    - otherwise → RUN.
  - RUN: per cycle, evaluated in this priority:
    1. u==1 → M←x1, → DONE.
    2. v==1 → M←x2, → DONE.
    3. u even → u←u>>1; x1←x1 even ? x1>>1 : (x1+p)>>1.
    4. v even → same halving on v/x2.
    5. u≥v → u←u−v; x1←x1−x2, +p if borrow.
    6. else → v←v−u; x2←x2−x1, +p if borrow.
  - DONE: `flag`=1 for one cycle → IDLE.
- Arithmetic:
  - x1+p is computed at n+1 bits before the shift.
  - Subtractions are n-bit with borrow-out; on borrow add p and drop the carry.
  - Invariants: x1, x2 ∈ [0,p); u, v > 0 in RUN.
- `start` while `busy` is ignored; a new `start` is accepted the cycle after `flag`.
- Reset at any point:
  - → IDLE.
  - M=0, flag=0, busy=0, err=0.
  - The in-flight result is discarded.

## Timing
- Reset values: M=0, flag=0, busy=0, err=0; state IDLE.
- Latency from `start` sample to `flag`: 1 (LOAD) + k RUN cycles + 1, with k ≤ 4n+2.
  - Each subtraction is followed by a halving.
  - Halvings total ≤ 2n.
- A==1: RUN exits on its first cycle; `flag` is high 3 cycles after `start`.
- Error path: `flag` is high 2 cycles after `start` (LOAD → DONE).
- `M` and `err` update on the same edge that raises `flag`; both hold through IDLE.

## Configuration
- `MODINV_INPUT_REDUCE_EN`:
  - Defined: in LOAD, A ≥ p is reduced by one conditional subtraction (valid for A < 2p) before the zero check. A=p therefore gives err=1; A=p+2 inverts as 2.
  - Undefined: A ≥ p gives err=1 with no reduction; the comparator is still present, the subtractor is removed.

## Structure
- Shared package `ecdsa_pkg`:
  - secp256k1 field prime P256K1 = FFFFFFFF…FFFFFFFE FFFFFC2F.
  - Group order N256K1.
  - FSM state encoding (IDLE/LOAD/RUN/DONE).
- Sub-module `mod_half_sub`: combinational n-bit helper that produces
  - (x+p)>>1 or x>>1, selected by x[0];
  - (x−y) mod p.
  It is instantiated twice, once for the x1 lane and once for the x2 lane.

## Test plan
- p=P256K1, A=1 → M=1, err=0, `flag` 3 cycles after `start`.
- A=2 → M=7FFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF 7FFFFE18 = (p+1)/2, err=0.
- A=p−1 → M=p−1.
- A=0 → err=1, M=0, `flag` 2 cycles after `start`.
- A=f3eaf3b95d6d94260bb91af829600303535b2b331893bd3d:
  - `modular_multiplier`(A, M) must return 1;
  - latency ≤ 4·256+4.
- Mid-RUN reset=0 for one cycle → outputs zero; a following `start` with A=2 returns (p+1)/2.
- A second `start` pulsed while `busy` is ignored.
- With `MODINV_INPUT_REDUCE_EN` defined, A=p+2 → M=(p+1)/2; without it → err=1.

Source files
------------

// File: rtl/ecdsa_pkg.sv
// Shared ECDSA datapath definitions: secp256k1 constants and the inverter FSM encoding.
package ecdsa_pkg;

  localparam logic [255:0] P256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] N256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } inv_state_t;

endpackage

// File: rtl/mod_half_sub.sv
// Combinational lane helper for the binary inverter: modular halving of x and (x - y) mod p.
module mod_half_sub #(
  parameter int unsigned n = 256
) (
  input  logic [n-1:0] p,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n-1:0] half,
  output logic [n-1:0] diff
);

  logic [n:0] sum;
  logic [n:0] sub;

  always_comb begin
    // Odd x: add p at n+1 bits so the carry survives the shift.
    sum  = {1'b0, x} + {1'b0, p};
    half = x[0] ? sum[n:1] : {1'b0, x[n-1:1]};
    sub  = {1'b0, x} - {1'b0, y};
    diff = sub[n] ? (sub[n-1:0] + p) : sub[n-1:0];
  end

endmodule

// File: rtl/modular_inverter.sv
// Binary extended Euclidean inverter, one reduction step per clock.
// Optional feature macro: MODINV_INPUT_REDUCE_EN (reduce A in [p, 2p) by one subtraction in LOAD).
module modular_inverter
  import ecdsa_pkg::*;
#(
  parameter int unsigned n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] p,
  output logic [n-1:0] M,
  output logic         flag,
  output logic         busy,
  output logic         err
);

  inv_state_t   state;
  logic [n-1:0] a_reg;
  logic [n-1:0] p_reg;
  logic [n-1:0] u;
  logic [n-1:0] v;
  logic [n-1:0] x1;
  logic [n-1:0] x2;

  logic [n-1:0] x1_half;
  logic [n-1:0] x1_diff;
  logic [n-1:0] x2_half;
  logic [n-1:0] x2_diff;

  logic [n-1:0] a_load;
  logic         load_err;

  mod_half_sub #(.n(n)) u_lane_x1 (
    .p    (p_reg),
    .x    (x1),
    .y    (x2),
    .half (x1_half),
    .diff (x1_diff)
  );

  mod_half_sub #(.n(n)) u_lane_x2 (
    .p    (p_reg),
    .x    (x2),
    .y    (x1),
    .half (x2_half),
    .diff (x2_diff)
  );

`ifdef MODINV_INPUT_REDUCE_EN
  logic [n:0] a_minus_p;

  always_comb begin
    a_minus_p = {1'b0, a_reg} - {1'b0, p_reg};
    a_load    = a_minus_p[n] ? a_reg : a_minus_p[n-1:0];
    load_err  = (a_load == '0);
  end
`else
  always_comb begin
    a_load   = a_reg;
    load_err = (a_reg == '0) || (a_reg >= p_reg);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      M     <= '0;
      flag  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            p_reg <= p;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          u  <= a_load;
          v  <= p_reg;
          x1 <= n'(1);
          x2 <= '0;
          if (load_err) begin
            M     <= '0;
            err   <= 1'b1;
            flag  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (u == n'(1)) begin
            M     <= x1;
            err   <= 1'b0;
            flag  <= 1'b1;
            state <= DONE;
          end else if (v == n'(1)) begin
            M     <= x2;
            err   <= 1'b0;
            flag  <= 1'b1;
            state <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_diff;
          end else begin
            v  <= v - u;
            x2 <= x2_diff;
          end
        end
        DONE: begin
          flag  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverter.sv
// Directed vector bench for modular_inverter over the secp256k1 field prime.
module tb_modular_inverter;
  import ecdsa_pkg::*;

  localparam int unsigned N = 256;
  localparam int unsigned LAT_MAX = 4 * 256 + 4;
  localparam int unsigned BOUND = 1200;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] p = P256K1;
  logic [N-1:0] M;
  logic         flag;
  logic         busy;
  logic         err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] m;
    logic         e;
    bit           prod;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  modular_inverter #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .p     (p),
    .M     (M),
    .flag  (flag),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input int poke_at, output int lat, output logic got);
    @(negedge clk);
    A = a;
    start = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < int'(BOUND); i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (lat == 1) check("busy_after_start", N'(busy), N'(1));
      if (flag) begin
        got = 1'b1;
        break;
      end
      if (poke_at != 0 && lat == poke_at) begin
        A = N'(2);
        start = 1'b1;
      end
    end
  endtask

  task automatic check_result(input vec_t v, input int lat, input logic got);
    logic [2*N-1:0] pr;
    check({v.name, "_flag"}, N'(got), N'(1));
    check({v.name, "_err"}, N'(err), N'(v.e));
    if (v.prod) begin
      pr = ({{N{1'b0}}, v.a} * {{N{1'b0}}, M}) % {{N{1'b0}}, p};
      check({v.name, "_prod"}, pr[N-1:0], N'(1));
    end else begin
      check({v.name, "_M"}, M, v.m);
    end
    if (v.lat != 0) check({v.name, "_lat"}, N'(lat), N'(v.lat));
    else check({v.name, "_lat_bound"}, N'(lat <= int'(LAT_MAX)), N'(1));
  endtask

  initial begin
    logic [N-1:0] half;
    logic [N-1:0] held;
    vec_t         v;
    int           lat;
    logic         got;

    half = (P256K1 + N'(1)) >> 1;
    vecs.push_back('{"a1", N'(1), N'(1), 1'b0, 1'b0, 3});
    vecs.push_back('{"a2", N'(2), half, 1'b0, 1'b0, 0});
    vecs.push_back('{"a0", '0, '0, 1'b1, 1'b0, 2});
    vecs.push_back('{"pm1", P256K1 - N'(1), P256K1 - N'(1), 1'b0, 1'b0, 0});
    vecs.push_back('{"ap", P256K1, '0, 1'b1, 1'b0, 2});
    vecs.push_back('{"f3ea", 256'hf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d, '0, 1'b0, 1'b1, 0});
    vecs.push_back('{"a3", N'(3), '0, 1'b0, 1'b1, 0});
    vecs.push_back('{"order", N256K1, '0, 1'b0, 1'b1, 0});
`ifdef MODINV_INPUT_REDUCE_EN
    vecs.push_back('{"pp2", P256K1 + N'(2), half, 1'b0, 1'b0, 0});
`else
    vecs.push_back('{"pp2", P256K1 + N'(2), '0, 1'b1, 1'b0, 2});
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_M", M, '0);
    check("rst_flag", N'(flag), '0);
    check("rst_busy", N'(busy), '0);
    check("rst_err", N'(err), '0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.a, 0, lat, got);
      check_result(v, lat, got);
      held = M;
      @(posedge clk);
      #1;
      check({v.name, "_flag_drop"}, N'(flag), '0);
      check({v.name, "_busy_drop"}, N'(busy), '0);
      check({v.name, "_M_hold"}, M, held);
    end

    // start pulsed mid-RUN must not disturb the operation in flight
    v = vecs[5];
    v.name = "ignore_start";
    run_op(v.a, 6, lat, got);
    check_result(v, lat, got);

    // reset mid-RUN, then a clean A=2 operation
    @(negedge clk);
    A = N'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_M", M, '0);
    check("midrst_flag", N'(flag), '0);
    check("midrst_busy", N'(busy), '0);
    check("midrst_err", N'(err), '0);
    @(negedge clk);
    reset = 1'b1;
    v = vecs[1];
    v.name = "after_rst_a2";
    run_op(v.a, 0, lat, got);
    check_result(v, lat, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
